// File: rtl/pll_ext_feedback_ready_monitor.sv
// FREF-domain monitor for the external-feedback PLL start-up sequencer. It
// qualifies READY from lock, stability and output enable, and reports faults.
module pll_ext_feedback_ready_monitor #(
  parameter logic [15:0] LOCK_STABLE_CYCLES  = 16'd256,
  parameter logic [15:0] LOCK_TIMEOUT_CYCLES = 16'd50000
) (
  input  logic       FREF,
  input  logic       RESET_N,
  input  logic       POWERDOWN_N,
  input  logic       OUTx_EN,
  input  logic       PLL_LOCK,
  output logic       READY,
  output logic       LOCK_LOST,
  output logic       TIMEOUT,
  output logic       RESTART_REQ,
  output logic [2:0] STATE
);

  typedef enum logic [2:0] {
    S_OFF       = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_WAIT_EN   = 3'd3,
    S_READY     = 3'd4,
    S_FAULT     = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_cnt;
  logic [15:0] w_cnt_next;
  logic        r_pd_q;
  logic        r_en_q;
  logic        r_lock_s1;
  logic        r_lock_s2;
  logic        r_ready;
  logic        r_lock_lost;
  logic        r_timeout;
  logic        r_restart_req;
  logic        w_set_lost;
  logic        w_set_timeout;

  // PLL_LOCK is asynchronous to FREF; the sequencer inputs are already FREF-timed.
  always_ff @(posedge FREF or negedge RESET_N) begin
    if (!RESET_N) begin
      r_pd_q    <= 1'b0;
      r_en_q    <= 1'b0;
      r_lock_s1 <= 1'b0;
      r_lock_s2 <= 1'b0;
    end else begin
      r_pd_q    <= POWERDOWN_N;
      r_en_q    <= OUTx_EN;
      r_lock_s1 <= PLL_LOCK;
      r_lock_s2 <= r_lock_s1;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_set_lost    = 1'b0;
    w_set_timeout = 1'b0;
    case (r_state)
      S_OFF: begin
        if (r_pd_q) w_state_next = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (!r_pd_q) w_state_next = S_OFF;
        else if (r_lock_s2) w_state_next = S_STABLE;
        else if (r_cnt == LOCK_TIMEOUT_CYCLES - 16'd1) begin
          w_state_next  = S_FAULT;
          w_set_timeout = 1'b1;
        end else w_cnt_next = r_cnt + 16'd1;
      end
      S_STABLE: begin
        if (!r_pd_q) w_state_next = S_OFF;
        else if (!r_lock_s2) w_state_next = S_WAIT_LOCK;
        else if (r_cnt == LOCK_STABLE_CYCLES - 16'd1) w_state_next = S_WAIT_EN;
        else w_cnt_next = r_cnt + 16'd1;
      end
      S_WAIT_EN: begin
        if (!r_pd_q) w_state_next = S_OFF;
        else if (!r_lock_s2) begin
          w_state_next = S_FAULT;
          w_set_lost   = 1'b1;
        end else if (r_en_q) w_state_next = S_READY;
      end
      S_READY: begin
        if (!r_pd_q) w_state_next = S_OFF;
        else if (!r_lock_s2) begin
          w_state_next = S_FAULT;
          w_set_lost   = 1'b1;
        end else if (!r_en_q) w_state_next = S_OFF;
      end
      S_FAULT: begin
        if (!r_pd_q) w_state_next = S_OFF;
      end
      default: w_state_next = S_OFF;
    endcase
    // Any state change restarts the cycle counter.
    if (w_state_next != r_state) w_cnt_next = 16'd0;
  end

  // READY and RESTART_REQ are decoded from the next state so they move on
  // the same edge as STATE.
  always_ff @(posedge FREF or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state       <= S_OFF;
      r_cnt         <= 16'd0;
      r_ready       <= 1'b0;
      r_lock_lost   <= 1'b0;
      r_timeout     <= 1'b0;
      r_restart_req <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_cnt         <= w_cnt_next;
      r_ready       <= (w_state_next == S_READY);
      r_lock_lost   <= r_lock_lost | w_set_lost;
      r_timeout     <= r_timeout | w_set_timeout;
      r_restart_req <= (w_state_next == S_FAULT) && (r_state != S_FAULT);
    end
  end

  assign READY       = r_ready;
  assign LOCK_LOST   = r_lock_lost;
  assign TIMEOUT     = r_timeout;
  assign RESTART_REQ = r_restart_req;
  assign STATE       = r_state;

endmodule
